// File: rtl/alu_reservation_station.sv
// Reservation station in front of the integer ALU.
// Holds dispatched micro-ops in a compacting queue (index 0 is oldest), snoops
// the CDB for missing operands and presents the oldest fully ready micro-op.
module alu_reservation_station #(
  parameter int unsigned BITWIDTH = 32,
  parameter int unsigned NENTRIES = 4,
  parameter int unsigned TAGW     = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [2:0]                         in_op,
  input  logic [TAGW-1:0]                    in_dest_tag,
  input  logic                               in_src1_val,
  input  logic                               in_src2_val,
  input  logic [TAGW-1:0]                    in_src1_tag,
  input  logic [TAGW-1:0]                    in_src2_tag,
  input  logic [BITWIDTH-1:0]                in_src1_data,
  input  logic [BITWIDTH-1:0]                in_src2_data,
  input  logic                               cdb_valid,
  input  logic [TAGW-1:0]                    cdb_tag,
  input  logic [BITWIDTH-1:0]                cdb_data,
  output logic                               issue_valid,
  input  logic                               issue_ready,
  output logic [BITWIDTH-1:0]                issue_A,
  output logic [BITWIDTH-1:0]                issue_B,
  output logic [2:0]                         issue_op,
  output logic [TAGW-1:0]                    issue_tag,
  output logic [$clog2(NENTRIES+1)-1:0]      count
);

  localparam int unsigned CNTW = $clog2(NENTRIES + 1);

  typedef struct packed {
    logic                busy;
    logic [2:0]          op;
    logic [TAGW-1:0]     dest_tag;
    logic                s1_val;
    logic [TAGW-1:0]     s1_tag;
    logic [BITWIDTH-1:0] s1_data;
    logic                s2_val;
    logic [TAGW-1:0]     s2_tag;
    logic [BITWIDTH-1:0] s2_data;
  } entry_t;

  entry_t          ent_q   [NENTRIES];
  entry_t          ent_d   [NENTRIES];
  entry_t          ent_ext [NENTRIES+1];
  entry_t          shifted;
  entry_t          new_ent;
  logic [CNTW-1:0] count_q;
  logic [CNTW-1:0] count_d;
  logic [CNTW-1:0] sel_idx;
  logic [CNTW-1:0] wr_idx;
  logic            sel_found;
  logic            do_dispatch;
  logic            issue_fire;

  // Capture a broadcast result into any waiting source of a busy entry.
  function automatic entry_t snoop(input entry_t e, input logic cv,
                                   input logic [TAGW-1:0] ct,
                                   input logic [BITWIDTH-1:0] cd);
    entry_t r;
    r = e;
    if (e.busy && cv) begin
      if (!e.s1_val && (e.s1_tag == ct)) begin
        r.s1_val  = 1'b1;
        r.s1_data = cd;
      end
      if (!e.s2_val && (e.s2_tag == ct)) begin
        r.s2_val  = 1'b1;
        r.s2_data = cd;
      end
    end
    return r;
  endfunction

  assign in_ready    = (count_q < CNTW'(NENTRIES));
  assign count       = count_q;
  assign do_dispatch = in_valid && in_ready;
  assign issue_fire  = sel_found && issue_ready;
  assign issue_valid = sel_found;

  // Oldest-first select of a ready entry; outputs are zero when none is ready.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    issue_A   = '0;
    issue_B   = '0;
    issue_op  = '0;
    issue_tag = '0;
    for (int i = 0; i < int'(NENTRIES); i++) begin
      if (!sel_found && ent_q[i].busy && ent_q[i].s1_val && ent_q[i].s2_val) begin
        sel_found = 1'b1;
        sel_idx   = CNTW'(i);
        issue_A   = ent_q[i].s1_data;
        issue_B   = ent_q[i].s2_data;
        issue_op  = ent_q[i].op;
        issue_tag = ent_q[i].dest_tag;
      end
    end
  end

  // Next state: compact over the issued slot, snoop the CDB, append dispatch.
  always_comb begin
    shifted = '0;
    for (int i = 0; i < int'(NENTRIES); i++) begin
      ent_ext[i] = ent_q[i];
    end
    ent_ext[NENTRIES] = '0;

    new_ent          = '0;
    new_ent.busy     = 1'b1;
    new_ent.op       = in_op;
    new_ent.dest_tag = in_dest_tag;
    new_ent.s1_val   = in_src1_val;
    new_ent.s1_tag   = in_src1_tag;
    new_ent.s1_data  = in_src1_data;
    new_ent.s2_val   = in_src2_val;
    new_ent.s2_tag   = in_src2_tag;
    new_ent.s2_data  = in_src2_data;
    new_ent          = snoop(new_ent, cdb_valid, cdb_tag, cdb_data);

    wr_idx = count_q - CNTW'(issue_fire);

    for (int i = 0; i < int'(NENTRIES); i++) begin
      if (issue_fire && (CNTW'(i) >= sel_idx)) begin
        shifted = ent_ext[i+1];
      end else begin
        shifted = ent_ext[i];
      end
      ent_d[i] = snoop(shifted, cdb_valid, cdb_tag, cdb_data);
      if (do_dispatch && (CNTW'(i) == wr_idx)) begin
        ent_d[i] = new_ent;
      end
    end

    count_d = count_q + CNTW'(do_dispatch) - CNTW'(issue_fire);
  end

  // Station state; reset and flush clear every entry and override all activity.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < int'(NENTRIES); i++) begin
        ent_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      for (int i = 0; i < int'(NENTRIES); i++) begin
        ent_q[i] <= ent_d[i];
      end
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Self-checking bench for alu_reservation_station: expected issues are queued
// when stimulus makes them certain and compared when the DUT presents them.
module tb_alu_reservation_station;

  localparam int BW = 32;
  localparam int NE = 4;
  localparam int TW = 4;

  typedef struct packed {
    logic [BW-1:0] a;
    logic [BW-1:0] b;
    logic [2:0]    op;
    logic [TW-1:0] tag;
  } exp_t;

  logic          clk, rst, flush, in_valid, in_ready;
  logic [2:0]    in_op;
  logic [TW-1:0] in_dest_tag, in_src1_tag, in_src2_tag;
  logic          in_src1_val, in_src2_val;
  logic [BW-1:0] in_src1_data, in_src2_data;
  logic          cdb_valid;
  logic [TW-1:0] cdb_tag;
  logic [BW-1:0] cdb_data;
  logic          issue_valid, issue_ready;
  logic [BW-1:0] issue_A, issue_B;
  logic [2:0]    issue_op;
  logic [TW-1:0] issue_tag;
  logic [2:0]    count;

  exp_t sb[$];
  exp_t exp_v;
  exp_t got;
  int   checks   = 0;
  int   failures = 0;

  alu_reservation_station #(.BITWIDTH(BW), .NENTRIES(NE), .TAGW(TW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_dest_tag(in_dest_tag),
    .in_src1_val(in_src1_val), .in_src2_val(in_src2_val),
    .in_src1_tag(in_src1_tag), .in_src2_tag(in_src2_tag),
    .in_src1_data(in_src1_data), .in_src2_data(in_src2_data),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_A(issue_A), .issue_B(issue_B), .issue_op(issue_op),
    .issue_tag(issue_tag), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: inputs set at negedge are taken at posedge, outputs read at next negedge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_dispatch(input logic [2:0] op, input logic [TW-1:0] dtag,
                              input logic v1, input logic [TW-1:0] t1, input logic [BW-1:0] d1,
                              input logic v2, input logic [TW-1:0] t2, input logic [BW-1:0] d2);
    in_valid     = 1'b1;
    in_op        = op;
    in_dest_tag  = dtag;
    in_src1_val  = v1;
    in_src1_tag  = t1;
    in_src1_data = d1;
    in_src2_val  = v2;
    in_src2_tag  = t2;
    in_src2_data = d2;
  endtask

  task automatic set_cdb(input logic [TW-1:0] t, input logic [BW-1:0] d);
    cdb_valid = 1'b1;
    cdb_tag   = t;
    cdb_data  = d;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    cdb_valid = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_dispatch(3'd0, 4'd1, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd2);
    set_cdb(4'd1, 32'd9);
    cyc();
    checks++;
    if (count !== 3'd0) begin
      failures++; $display("FAIL reset_count: got %0d required 0", count);
    end
    checks++;
    if ({issue_valid, issue_A, issue_B, issue_op, issue_tag} !== '0) begin
      failures++; $display("FAIL reset_issue_outputs: got v=%b A=%h B=%h op=%0d tag=%0d required all 0",
                           issue_valid, issue_A, issue_B, issue_op, issue_tag);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    rst = 1'b0;
    idle();
    cyc();
    checks++;
    if (count !== 3'd0 || issue_valid !== 1'b0) begin
      failures++; $display("FAIL reset_release: got count=%0d v=%b required 0/0", count, issue_valid);
    end
  endtask

  task automatic test_ready_dispatch();
    issue_ready = 1'b1;
    set_dispatch(3'd0, 4'd3, 1'b1, 4'd0, 32'd5, 1'b1, 4'd0, 32'd7);
    sb.push_back('{a:32'd5, b:32'd7, op:3'd0, tag:4'd3});
    cyc();
    idle();
    checks++;
    if (issue_valid !== 1'b1 || sb.size() == 0) begin
      failures++; $display("FAIL ready_issue: got v=%b required 1", issue_valid);
    end else begin
      exp_v = sb.pop_front(); got = {issue_A, issue_B, issue_op, issue_tag};
      if (got !== exp_v) begin
        failures++; $display("FAIL ready_issue: got %h required %h", got, exp_v);
      end
    end
    cyc();
    checks++;
    if (count !== 3'd0 || issue_valid !== 1'b0) begin
      failures++; $display("FAIL ready_drain: got count=%0d v=%b required 0/0", count, issue_valid);
    end
  endtask

  task automatic test_wakeup();
    issue_ready = 1'b1;
    set_dispatch(3'd1, 4'd2, 1'b1, 4'd0, 32'd10, 1'b0, 4'd9, 32'd0);
    cyc();
    idle();
    checks++;
    if (issue_valid !== 1'b0 || count !== 3'd1) begin
      failures++; $display("FAIL wakeup_wait: got v=%b count=%0d required 0/1", issue_valid, count);
    end
    set_cdb(4'd9, 32'd4);
    sb.push_back('{a:32'd10, b:32'd4, op:3'd1, tag:4'd2});
    cyc();
    idle();
    checks++;
    if (issue_valid !== 1'b1 || sb.size() == 0) begin
      failures++; $display("FAIL wakeup_issue: got v=%b required 1", issue_valid);
    end else begin
      exp_v = sb.pop_front(); got = {issue_A, issue_B, issue_op, issue_tag};
      if (got !== exp_v) begin
        failures++; $display("FAIL wakeup_issue: got %h required %h", got, exp_v);
      end
    end
    cyc();
  endtask

  task automatic test_bypass();
    issue_ready = 1'b1;
    set_dispatch(3'd7, 4'd5, 1'b1, 4'd0, 32'h1234, 1'b0, 4'd6, 32'd0);
    set_cdb(4'd6, 32'hFFFF_FFFF);
    sb.push_back('{a:32'h1234, b:32'hFFFF_FFFF, op:3'd7, tag:4'd5});
    cyc();
    idle();
    checks++;
    if (issue_valid !== 1'b1 || sb.size() == 0) begin
      failures++; $display("FAIL bypass_issue: got v=%b required 1", issue_valid);
    end else begin
      exp_v = sb.pop_front(); got = {issue_A, issue_B, issue_op, issue_tag};
      if (got !== exp_v) begin
        failures++; $display("FAIL bypass_issue: got %h required %h", got, exp_v);
      end
    end
    cyc();
    checks++;
    if (count !== 3'd0) begin
      failures++; $display("FAIL bypass_drain: got count=%0d required 0", count);
    end
  endtask

  task automatic test_full_order();
    issue_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      set_dispatch(3'(k), 4'(k), 1'b1, 4'd0, 32'(k * 16), 1'b1, 4'd0, 32'(k));
      sb.push_back('{a:32'(k * 16), b:32'(k), op:3'(k), tag:4'(k)});
      cyc();
    end
    idle();
    checks++;
    if (count !== 3'd4 || in_ready !== 1'b0) begin
      failures++; $display("FAIL full_state: got count=%0d in_ready=%b required 4/0", count, in_ready);
    end
    checks++;
    if (issue_valid !== 1'b1 || issue_tag !== sb[0].tag) begin
      failures++; $display("FAIL full_hold_oldest: got v=%b tag=%0d required 1/%0d", issue_valid, issue_tag, sb[0].tag);
    end
    set_dispatch(3'd5, 4'd5, 1'b1, 4'd0, 32'd99, 1'b1, 4'd0, 32'd99);
    cyc();
    idle();
    checks++;
    if (count !== 3'd4) begin
      failures++; $display("FAIL full_refuse: got count=%0d required 4", count);
    end
    issue_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (issue_valid !== 1'b1 || sb.size() == 0) begin
        failures++; $display("FAIL full_order_issue%0d: got v=%b required 1", k, issue_valid);
      end else begin
        exp_v = sb.pop_front(); got = {issue_A, issue_B, issue_op, issue_tag};
        if (got !== exp_v) begin
          failures++; $display("FAIL full_order_issue%0d: got %h required %h", k, got, exp_v);
        end
      end
      cyc();
    end
    checks++;
    if (count !== 3'd0 || issue_valid !== 1'b0) begin
      failures++; $display("FAIL full_drain: got count=%0d v=%b required 0/0", count, issue_valid);
    end
  endtask

  task automatic test_out_of_order();
    issue_ready = 1'b0;
    set_dispatch(3'd2, 4'd10, 1'b1, 4'd0, 32'hF0, 1'b0, 4'd8, 32'd0);
    cyc();
    set_dispatch(3'd3, 4'd11, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd2);
    sb.push_back('{a:32'd1, b:32'd2, op:3'd3, tag:4'd11});
    cyc();
    set_dispatch(3'd4, 4'd12, 1'b0, 4'd13, 32'd0, 1'b1, 4'd0, 32'd3);
    cyc();
    idle();
    checks++;
    if (issue_valid !== 1'b1 || sb.size() == 0) begin
      failures++; $display("FAIL ooo_younger_first: got v=%b required 1", issue_valid);
    end else begin
      exp_v = sb.pop_front(); got = {issue_A, issue_B, issue_op, issue_tag};
      if (got !== exp_v) begin
        failures++; $display("FAIL ooo_younger_first: got %h required %h", got, exp_v);
      end
    end
    issue_ready = 1'b1;
    set_cdb(4'd13, 32'h55);
    sb.push_back('{a:32'h55, b:32'd3, op:3'd4, tag:4'd12});
    cyc();
    idle();
    checks++;
    if (issue_valid !== 1'b1 || sb.size() == 0) begin
      failures++; $display("FAIL ooo_capture_during_shift: got v=%b required 1", issue_valid);
    end else begin
      exp_v = sb.pop_front(); got = {issue_A, issue_B, issue_op, issue_tag};
      if (got !== exp_v) begin
        failures++; $display("FAIL ooo_capture_during_shift: got %h required %h", got, exp_v);
      end
    end
    set_cdb(4'd8, 32'h0F);
    sb.push_back('{a:32'hF0, b:32'h0F, op:3'd2, tag:4'd10});
    cyc();
    idle();
    checks++;
    if (issue_valid !== 1'b1 || sb.size() == 0) begin
      failures++; $display("FAIL ooo_oldest_wakeup: got v=%b required 1", issue_valid);
    end else begin
      exp_v = sb.pop_front(); got = {issue_A, issue_B, issue_op, issue_tag};
      if (got !== exp_v) begin
        failures++; $display("FAIL ooo_oldest_wakeup: got %h required %h", got, exp_v);
      end
    end
    cyc();
    checks++;
    if (count !== 3'd0) begin
      failures++; $display("FAIL ooo_drain: got count=%0d required 0", count);
    end
  endtask

  task automatic test_back_to_back();
    issue_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        checks++;
        if (issue_valid !== 1'b1 || count !== 3'd1 || sb.size() == 0) begin
          failures++; $display("FAIL b2b_issue%0d: got v=%b count=%0d required 1/1", k, issue_valid, count);
        end else begin
          exp_v = sb.pop_front(); got = {issue_A, issue_B, issue_op, issue_tag};
          if (got !== exp_v) begin
            failures++; $display("FAIL b2b_issue%0d: got %h required %h", k, got, exp_v);
          end
        end
      end
      set_dispatch(3'(k), 4'(k + 4), 1'b1, 4'd0, 32'(100 + k), 1'b1, 4'd0, 32'(k));
      sb.push_back('{a:32'(100 + k), b:32'(k), op:3'(k), tag:4'(k + 4)});
      cyc();
    end
    idle();
    checks++;
    if (issue_valid !== 1'b1 || sb.size() == 0) begin
      failures++; $display("FAIL b2b_last: got v=%b required 1", issue_valid);
    end else begin
      exp_v = sb.pop_front(); got = {issue_A, issue_B, issue_op, issue_tag};
      if (got !== exp_v) begin
        failures++; $display("FAIL b2b_last: got %h required %h", got, exp_v);
      end
    end
    cyc();
    checks++;
    if (count !== 3'd0) begin
      failures++; $display("FAIL b2b_drain: got count=%0d required 0", count);
    end
  endtask

  task automatic test_flush();
    logic [TW-1:0] wtags [3];
    wtags[0] = 4'd0; wtags[1] = 4'd14; wtags[2] = 4'd15;
    issue_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_dispatch(3'd0, 4'(k + 1), 1'b1, 4'd0, 32'd1, 1'b0, wtags[k], 32'd0);
      cyc();
    end
    idle();
    checks++;
    if (count !== 3'd3 || issue_valid !== 1'b0) begin
      failures++; $display("FAIL flush_setup: got count=%0d v=%b required 3/0", count, issue_valid);
    end
    flush = 1'b1;
    issue_ready = 1'b1;
    set_dispatch(3'd1, 4'd7, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd1);
    set_cdb(4'd0, 32'd77);
    cyc();
    idle();
    checks++;
    if (count !== 3'd0 || issue_valid !== 1'b0 || in_ready !== 1'b1 || issue_tag !== 4'd0) begin
      failures++; $display("FAIL flush_clear: got count=%0d v=%b in_ready=%b tag=%0d required 0/0/1/0",
                           count, issue_valid, in_ready, issue_tag);
    end
    for (int k = 0; k < 3; k++) begin
      set_cdb(wtags[k], 32'(200 + k));
      cyc();
      idle();
      checks++;
      if (issue_valid !== 1'b0 || count !== 3'd0) begin
        failures++; $display("FAIL flush_stale_tag%0d: got v=%b count=%0d required 0/0", k, issue_valid, count);
      end
    end
    set_dispatch(3'd5, 4'd0, 1'b1, 4'd0, 32'hFFFF_FFFD, 1'b0, 4'd0, 32'd0);
    cyc();
    idle();
    checks++;
    if (issue_valid !== 1'b0) begin
      failures++; $display("FAIL tag0_wait: got v=%b required 0", issue_valid);
    end
    set_cdb(4'd0, 32'd5);
    sb.push_back('{a:32'hFFFF_FFFD, b:32'd5, op:3'd5, tag:4'd0});
    cyc();
    idle();
    checks++;
    if (issue_valid !== 1'b1 || sb.size() == 0) begin
      failures++; $display("FAIL tag0_wakeup: got v=%b required 1", issue_valid);
    end else begin
      exp_v = sb.pop_front(); got = {issue_A, issue_B, issue_op, issue_tag};
      if (got !== exp_v) begin
        failures++; $display("FAIL tag0_wakeup: got %h required %h", got, exp_v);
      end
    end
    cyc();
    checks++;
    if (count !== 3'd0 || sb.size() != 0) begin
      failures++; $display("FAIL final_drain: got count=%0d queued=%0d required 0/0", count, sb.size());
    end
  endtask

  initial begin
    rst          = 1'b1;
    flush        = 1'b0;
    in_valid     = 1'b0;
    in_op        = '0;
    in_dest_tag  = '0;
    in_src1_val  = 1'b0;
    in_src2_val  = 1'b0;
    in_src1_tag  = '0;
    in_src2_tag  = '0;
    in_src1_data = '0;
    in_src2_data = '0;
    cdb_valid    = 1'b0;
    cdb_tag      = '0;
    cdb_data     = '0;
    issue_ready  = 1'b0;
    @(negedge clk);
    cyc();
    test_reset();
    test_ready_dispatch();
    test_wakeup();
    test_bypass();
    test_full_order();
    test_out_of_order();
    test_back_to_back();
    test_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
